alu_flag_branch_unit: RTL
=========================

Name: alu_flag_branch_unit

Overview:
- Sits at the output end of the 64-bit ALU and consumes its result flags: negative, zero, overflow and carry_out.
- Holds the architectural NZVC flag register and evaluates ARMv8 branch conditions (B.cond, CBZ, B).
- Produces a registered take/not-take decision for the fetch/PC logic.
- Closes the loop from ALU-produced flags to control flow.

Parameters:
- NUM_COND, 16, number of condition encodings decoded (fixed ARMv8 4-bit space).
- RESET_FLAGS, 4'b0000, NZVC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- set_flags  input  1  latch ALU flags this cycle (ADDS/SUBS/ANDS).
- flag_arith  input  1  1 = flags come from an add/subtract; 0 = logical op.
- negative_in  input  1  ALU negative.
- zero_in  input  1  ALU zero.
- overflow_in  input  1  ALU overflow.
- carry_in  input  1  ALU carry_out.
- br_valid  input  1  branch request this cycle.
- br_type  input  2  00 B.cond, 01 CBZ, 10 CBNZ, 11 B (unconditional).
- cond  input  4  ARMv8 condition field for B.cond.
- flags_q  output  4  registered NZVC {N,Z,V,C}.
- take_valid  output  1  decision valid (one cycle after br_valid).
- take_branch  output  1  registered decision.
- cond_invalid  output  1  pulses with take_valid when a B.cond uses cond 4'b1111.

Behaviour:
- Reset (synchronous, highest priority):
  - flags_q = RESET_FLAGS; take_valid = 0, take_branch = 0, cond_invalid = 0.
  - Any in-flight decision is discarded.
- Flag register:
  - set_flags=1 and flag_arith=1: load {negative_in, zero_in, overflow_in, carry_in}.
  - set_flags=1 and flag_arith=0: N, Z load from the ALU; V and C cleared to 0 (ANDS semantics). The ALU's V/C are undefined for logical ops and must not be sampled.
  - set_flags=0: hold.
- Condition evaluation on the effective flags F (see Optional Feature):
  - 0000 EQ Z; 0001 NE !Z; 0010 HS C; 0011 LO !C.
  - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
  - 1000 HI C&!Z; 1001 LS !C|Z.
  - 1010 GE N==V; 1011 LT N!=V.
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V).
  - 1110 AL 1; 1111 treated as AL, with cond_invalid asserted.
- CBZ/CBNZ:
  - Decision uses zero_in of the current ALU result (pass-B path), never the flag register.
  - CBZ takes on zero_in=1; CBNZ takes on zero_in=0.
  - flags_q is not modified unless set_flags is also asserted.
- B (br_type 11): always taken.
- Latency and output timing:
  - br_valid in cycle t produces take_valid=1 in cycle t+1, with take_branch and cond_invalid valid alongside.
  - take_valid is a single-cycle pulse per request.
  - Back-to-back br_valid produces back-to-back pulses (throughput 1/cycle).
- br_valid=0: take_valid=0 next cycle; take_branch holds its last value and is don't-care.
- Simultaneous set_flags and B.cond in the same cycle: which flags are used is governed by the Optional Feature.
- Reset asserted in the same cycle as br_valid or set_flags: reset wins; no decision is produced next cycle.

Optional Feature:
- Macro FLAG_BYPASS_EN.
- Defined: when set_flags and a B.cond request coincide, F is the post-update value (incoming flags with the logical-op V/C clear applied). This gives same-cycle forwarding.
- Undefined: F is always flags_q (pre-update). The pipeline must insert one bubble between a flag-setting instruction and a dependent B.cond.
- Both builds must pass the Test Plan; scenario 4 has per-build expected values.

Test Plan:
1. reset=1 for 2 cycles, then released → flags_q=4'b0000, take_valid=0. Then B.cond EQ with br_valid=1 → next cycle take_valid=1, take_branch=0.
2. set_flags=1, flag_arith=1, N=0 Z=1 V=0 C=1 (SUBS equal operands).
   - Next cycle flags_q=4'b0101.
   - Subsequent B.cond HS → taken; HI → not taken; GE → taken; GT → not taken.
3. flags_q=4'b0011, then set_flags=1, flag_arith=0, N=1 Z=0, V_in=1 C_in=1 → flags_q=4'b1000.
   - MI → taken; VS → not taken; LT → taken.
4. With flags_q=4'b0000, the same cycle carries set_flags=1 (arith, Z=1) and B.cond EQ.
   - With FLAG_BYPASS_EN: take_branch=1.
   - Without FLAG_BYPASS_EN: take_branch=0. flags_q=4'b0100 afterwards in both builds.
5. CBZ with zero_in=1 and flags_q Z=0 → taken. CBNZ with zero_in=1 → not taken. flags_q unchanged in both cases.
6. B.cond cond=4'b1111 → take_branch=1, cond_invalid=1 for one cycle. Then reset asserted in the same cycle as br_valid → take_valid=0 next cycle and flags_q=4'b0000.

Source files
------------

// File: rtl/alu_flag_branch_unit_if.sv
// Flag-update and branch-request bundle between the ALU/decode stage and the
// flag/branch unit. The master drives requests; the slave returns flags and decisions.
interface alu_flag_branch_unit_if;
  logic       set_flags;
  logic       flag_arith;
  logic       negative_in;
  logic       zero_in;
  logic       overflow_in;
  logic       carry_in;
  logic       br_valid;
  logic [1:0] br_type;
  logic [3:0] cond;
  logic [3:0] flags_q;
  logic       take_valid;
  logic       take_branch;
  logic       cond_invalid;

  modport master (
    output set_flags, flag_arith, negative_in, zero_in, overflow_in, carry_in,
    output br_valid, br_type, cond,
    input  flags_q, take_valid, take_branch, cond_invalid
  );

  modport slave (
    input  set_flags, flag_arith, negative_in, zero_in, overflow_in, carry_in,
    input  br_valid, br_type, cond,
    output flags_q, take_valid, take_branch, cond_invalid
  );
endinterface

// File: rtl/alu_flag_branch_unit.sv
// NZVC flag register plus ARMv8 branch-condition evaluator with a registered decision.
// Define FLAG_BYPASS_EN to forward same-cycle flag updates into a coincident B.cond.
module alu_flag_branch_unit #(
  parameter int         NUM_COND    = 16,
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input logic                   clk,
  input logic                   reset,
  alu_flag_branch_unit_if.slave bus
);

  typedef enum logic [1:0] {
    BR_COND   = 2'b00,
    BR_CBZ    = 2'b01,
    BR_CBNZ   = 2'b10,
    BR_ALWAYS = 2'b11
  } br_type_e;

  logic [3:0]          flags_r;
  logic [3:0]          flags_next;
  logic [3:0]          flags_eff;
  logic [NUM_COND-1:0] cond_true;
  logic                decision;
  logic                is_bad_cond;
  logic                take_valid_r;
  logic                take_branch_r;
  logic                cond_invalid_r;
  br_type_e            br_type;

  assign br_type = br_type_e'(bus.br_type);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    flags_next = flags_r;
    if (bus.set_flags) begin
      // Logical ops leave the ALU's V/C undefined, so they are cleared rather than sampled.
      flags_next = bus.flag_arith
                 ? {bus.negative_in, bus.zero_in, bus.overflow_in, bus.carry_in}
                 : {bus.negative_in, bus.zero_in, 2'b00};
    end
  end

`ifdef FLAG_BYPASS_EN
  assign flags_eff = flags_next;
`else
  assign flags_eff = flags_r;
`endif

  // Truth of every condition encoding on the effective {N,Z,V,C}.
  always_comb begin
    logic n, z, v, c;
    {n, z, v, c}  = flags_eff;
    cond_true     = '0;
    cond_true[0]  = z;
    cond_true[1]  = !z;
    cond_true[2]  = c;
    cond_true[3]  = !c;
    cond_true[4]  = n;
    cond_true[5]  = !n;
    cond_true[6]  = v;
    cond_true[7]  = !v;
    cond_true[8]  = c && !z;
    cond_true[9]  = !c || z;
    cond_true[10] = (n == v);
    cond_true[11] = (n != v);
    cond_true[12] = !z && (n == v);
    cond_true[13] = z || (n != v);
    cond_true[14] = 1'b1;
    cond_true[15] = 1'b1;
  end

  // CBZ/CBNZ look at the live ALU zero, never the flag register.
  always_comb begin
    decision = 1'b0;
    case (br_type)
      BR_COND:   decision = cond_true[bus.cond];
      BR_CBZ:    decision = bus.zero_in;
      BR_CBNZ:   decision = !bus.zero_in;
      BR_ALWAYS: decision = 1'b1;
      default:   decision = 1'b0;
    endcase
  end

  assign is_bad_cond = (br_type == BR_COND) && (bus.cond == 4'b1111);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_r        <= RESET_FLAGS;
      take_valid_r   <= 1'b0;
      take_branch_r  <= 1'b0;
      cond_invalid_r <= 1'b0;
    end else begin
      flags_r        <= flags_next;
      take_valid_r   <= bus.br_valid;
      cond_invalid_r <= bus.br_valid && is_bad_cond;
      if (bus.br_valid) begin
        take_branch_r <= decision;
      end
    end
  end

  assign bus.flags_q      = flags_r;
  assign bus.take_valid   = take_valid_r;
  assign bus.take_branch  = take_branch_r;
  assign bus.cond_invalid = cond_invalid_r;

endmodule
